// File: rtl/display_scanner.sv
// display_scanner: multiplexed 7-segment scanner with per-frame input snapshot,
// leading-zero suppression, inter-digit blanking and brightness windowing.
module display_scanner #(
    parameter int N_DIGITOS    = 4,
    parameter int CLK_DIV      = 500,
    parameter int T_MUESTRA    = 100,
    parameter int T_BLANKING   = 10,
    parameter int DIG_ACT_BAJO = 1,
    parameter int SEG_ACT_BAJO = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [4*N_DIGITOS-1:0] numero,
    input  logic [N_DIGITOS-1:0]   puntos,
    input  logic [N_DIGITOS-1:0]   apagar,
    input  logic                   supresion_ceros,
    input  logic [3:0]             brillo,
    output logic [7:0]             segmentos,
    output logic [N_DIGITOS-1:0]   digitos,
    output logic                   frame_tick
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [N_DIGITOS-1:0] DIG_OFF = (DIG_ACT_BAJO != 0) ? '1 : '0;
    localparam logic [7:0] SEG_OFF = (SEG_ACT_BAJO != 0) ? '1 : '0;
    typedef enum logic {MUESTRA, BLANKING} state_t;
    state_t state, state_n;
    logic [PW-1:0] pres;
    logic tick, new_frame, z, bl, pt, lit;
    logic [2:0] idx, idx_n;
    logic [9:0] cnt, cnt_n, k;
    logic [4*N_DIGITOS-1:0] s_num, s_num_n;
    logic [N_DIGITOS-1:0] s_pts, s_pts_n, s_apg, s_apg_n, dig_on;
    logic s_sup, s_sup_n;
    logic [3:0] s_bri, s_bri_n, nib;
    logic [7:0] seg_on;
    logic [15:0] k16, win16;
    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: dec = 7'h3F; 4'h1: dec = 7'h06; 4'h2: dec = 7'h5B; 4'h3: dec = 7'h4F;
            4'h4: dec = 7'h66; 4'h5: dec = 7'h6D; 4'h6: dec = 7'h7D; 4'h7: dec = 7'h07;
            4'h8: dec = 7'h7F; 4'h9: dec = 7'h6F; 4'hA: dec = 7'h77; 4'hB: dec = 7'h7C;
            4'hC: dec = 7'h39; 4'hD: dec = 7'h5E; 4'hE: dec = 7'h79; default: dec = 7'h71;
        endcase
    endfunction
    assign tick = pres == PW'(CLK_DIV - 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pres <= '0;
        else pres <= tick ? '0 : pres + PW'(1);
    end
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cnt_n     = cnt;
        new_frame = 1'b0;
        if (tick) begin
            if (cnt == 10'd0) begin
                if (state == MUESTRA) begin
                    state_n = BLANKING;
                    cnt_n   = 10'(T_BLANKING - 1);
                end else begin
                    state_n   = MUESTRA;
                    idx_n     = (idx == 3'd0) ? 3'(N_DIGITOS - 1) : idx - 3'd1;
                    cnt_n     = 10'(T_MUESTRA - 1);
                    new_frame = idx == 3'd0;
                end
            end else cnt_n = cnt - 10'd1;
        end
    end
    assign s_num_n = new_frame ? numero : s_num;
    assign s_pts_n = new_frame ? puntos : s_pts;
    assign s_apg_n = new_frame ? apagar : s_apg;
    assign s_sup_n = new_frame ? supresion_ceros : s_sup;
    assign s_bri_n = new_frame ? brillo : s_bri;
    // Outputs are derived from next-cycle values so they change on the same edge as the FSM.
    always_comb begin
        z   = 1'b1;
        nib = 4'd0;
        pt  = 1'b0;
        bl  = 1'b0;
        for (int i = N_DIGITOS - 1; i >= 0; i--) begin
            z = z & (s_num_n[4*i +: 4] == 4'd0);
            if (3'(i) == idx_n) begin
                nib = s_num_n[4*i +: 4];
                pt  = s_pts_n[i];
                bl  = s_apg_n[i] | (s_sup_n & z & (i != 0));
            end
        end
    end
    assign k      = 10'(T_MUESTRA - 1) - cnt_n;
    assign k16    = {2'b00, k, 4'b0000};
    assign win16  = 16'({1'b0, s_bri_n} + 5'd1) * 16'(T_MUESTRA);
    assign lit    = (state_n == MUESTRA) && !bl && (k16 < win16);
    assign dig_on = lit ? N_DIGITOS'(1) << idx_n : '0;
    assign seg_on = lit ? {pt, dec(nib)} : 8'h00;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= BLANKING;
            idx        <= '0;
            cnt        <= '0;
            s_num      <= '0;
            s_pts      <= '0;
            s_apg      <= '0;
            s_sup      <= 1'b0;
            s_bri      <= '0;
            digitos    <= DIG_OFF;
            segmentos  <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            s_num      <= s_num_n;
            s_pts      <= s_pts_n;
            s_apg      <= s_apg_n;
            s_sup      <= s_sup_n;
            s_bri      <= s_bri_n;
            digitos    <= dig_on ^ DIG_OFF;
            segmentos  <= seg_on ^ SEG_OFF;
            frame_tick <= new_frame;
        end
    end
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: table-driven scoreboard bench for display_scanner
// (N=4, CLK_DIV=4, T_MUESTRA=8, T_BLANKING=2).
module tb_display_scanner;
    logic clk = 1'b0, reset_n = 1'b0;
    logic [15:0] numero = '0;
    logic [3:0] puntos = '0, apagar = '0, brillo = '0, digitos;
    logic supresion_ceros = 1'b0, frame_tick;
    logic [7:0] segmentos;
    always #5 clk = ~clk;
    display_scanner #(.N_DIGITOS(4), .CLK_DIV(4), .T_MUESTRA(8), .T_BLANKING(2)) dut (
        .clk(clk), .reset_n(reset_n), .numero(numero), .puntos(puntos), .apagar(apagar),
        .supresion_ceros(supresion_ceros), .brillo(brillo), .segmentos(segmentos),
        .digitos(digitos), .frame_tick(frame_tick)
    );
    typedef struct {
        string name;
        logic [15:0] num, num2;
        int chg;
        logic [3:0] pts, apg;
        logic sup;
        logic [3:0] bri;
        int lit_ticks;
        logic [3:0] blk;
        logic [31:0] seg0, seg1;
    } vec_t;
    typedef struct {
        logic [3:0] dig;
        logic [7:0] seg;
        logic ft;
    } exp_t;
    vec_t vecs[8];
    exp_t sb[$];
    int total = 0, bad = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask
    // Expected outputs after clk edge e (1-based from reset release), from elapsed time alone.
    function automatic exp_t model(input vec_t v, input int e);
        exp_t r;
        int t, p, f, d, w;
        logic [31:0] s;
        r.dig = 4'hF;
        r.seg = 8'h00;
        r.ft  = 1'b0;
        t = e / 4;
        if (t == 0) return r;
        p = (t - 1) % 40;
        f = (t - 1) / 40;
        d = 3 - p / 10;
        w = p % 10;
        r.ft = (e % 4 == 0) && (p == 0);
        s = (f == 0) ? v.seg0 : v.seg1;
        if (w < 8 && !v.blk[d] && w < v.lit_ticks) begin
            r.dig = ~(4'b0001 << d);
            r.seg = s[8*d +: 8];
        end
        return r;
    endfunction
    task automatic run(input vec_t v, input int edges);
        exp_t x;
        reset_n = 1'b0;
        numero = v.num;
        puntos = v.pts;
        apagar = v.apg;
        supresion_ceros = v.sup;
        brillo = v.bri;
        #1;
        check({v.name, " reset"}, {19'd0, digitos, segmentos, frame_tick}, {19'd0, 4'hF, 8'h00, 1'b0});
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= edges; e++) begin
            @(posedge clk);
            sb.push_back(model(v, e));
            @(negedge clk);
            if (v.chg == e) numero = v.num2;
            x = sb.pop_front();
            check($sformatf("%s e%0d", v.name, e), {19'd0, digitos, segmentos, frame_tick},
                  {19'd0, x.dig, x.seg, x.ft});
        end
    endtask
    initial begin
        vecs[0] = '{"hex12AF",   16'h12AF, 16'h12AF, 0,  4'b0000, 4'b0000, 1'b0, 4'd15, 8, 4'b0000, 32'h065B7771, 32'h065B7771};
        vecs[1] = '{"supp0070",  16'h0070, 16'h0070, 0,  4'b0000, 4'b0000, 1'b1, 4'd15, 8, 4'b1100, 32'h0000073F, 32'h0000073F};
        vecs[2] = '{"supp0000",  16'h0000, 16'h0000, 0,  4'b0000, 4'b0000, 1'b1, 4'd15, 8, 4'b1110, 32'h0000003F, 32'h0000003F};
        vecs[3] = '{"supp0F00",  16'h0F00, 16'h0F00, 0,  4'b0000, 4'b0000, 1'b1, 4'd15, 8, 4'b1000, 32'h00713F3F, 32'h00713F3F};
        vecs[4] = '{"dp_apagar", 16'h8888, 16'h8888, 0,  4'b0100, 4'b0001, 1'b0, 4'd15, 8, 4'b0001, 32'h7FFF7F00, 32'h7FFF7F00};
        vecs[5] = '{"bri0",      16'h12AF, 16'h12AF, 0,  4'b0000, 4'b0000, 1'b0, 4'd0,  1, 4'b0000, 32'h065B7771, 32'h065B7771};
        vecs[6] = '{"bri7",      16'h12AF, 16'h12AF, 0,  4'b0000, 4'b0000, 1'b0, 4'd7,  4, 4'b0000, 32'h065B7771, 32'h065B7771};
        vecs[7] = '{"midchg",    16'h1111, 16'h2222, 48, 4'b0000, 4'b0000, 1'b0, 4'd15, 8, 4'b0000, 32'h06060606, 32'h5B5B5B5B};
        @(negedge clk);
        for (int i = 0; i < 8; i++) run(vecs[i], 330);
        run(vecs[0], 50);
        check("pre_reset lit", {28'd0, digitos}, {28'd0, 4'b1011});
        run(vecs[0], 330);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter N_DIGITOS, default 4, SHALL set the number of multiplexed digits (legal range 1..8).
REQ-003 Parameter CLK_DIV, default 500, SHALL set the clk cycles per scan tick (10 us at 50 MHz); legal range >= 2.
REQ-004 Parameter T_MUESTRA, default 100, SHALL set the ticks per digit show phase; legal range 1..1023.
REQ-005 Parameter T_BLANKING, default 10, SHALL set the ticks per inter-digit blank phase; legal range 1..1023.
REQ-006 Parameter DIG_ACT_BAJO, default 1, SHALL select the digit-line polarity: 1 = active-low (common cathode).
REQ-007 Parameter SEG_ACT_BAJO, default 0, SHALL select the segment-line polarity: 0 = active-high.
REQ-008 The ports SHALL be:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- numero  in  4*N_DIGITOS  hex nibbles, MSD in the top nibble
- puntos  in  N_DIGITOS  decimal point per digit, bit i = digit i
- apagar  in  N_DIGITOS  force digit i blank
- supresion_ceros  in  1  leading-zero suppression enable
- brillo  in  4  brightness, 0..15
- segmentos  out  8  pGFEDCBA
- digitos  out  N_DIGITOS  digit enables, MSD = top bit
- frame_tick  out  1  one-clk pulse at frame start

Function
REQ-009 A prescaler SHALL assert an internal tick for one clk every CLK_DIV clk cycles; the first tick SHALL occur CLK_DIV cycles after reset_n deasserts.
REQ-010 All outputs SHALL be registered, and the FSM SHALL change state only on clk edges where the tick is high; no derived clocks are permitted.
REQ-011 The FSM SHALL have states MUESTRA and BLANKING, a digit index, and a 10-bit tick down-counter; a transition SHALL occur on a tick when the counter equals 0, otherwise the counter SHALL decrement.
REQ-012 The scan sequence SHALL be MUESTRA(N-1), BLANKING, MUESTRA(N-2), BLANKING, ..., MUESTRA(0), BLANKING, then wrap to MUESTRA(N-1).
- MUESTRA SHALL last exactly T_MUESTRA ticks.
- BLANKING SHALL last exactly T_BLANKING ticks.
- Frame period SHALL be N_DIGITOS*(T_MUESTRA+T_BLANKING) ticks.
REQ-013 On entry to MUESTRA(N-1), the block SHALL snapshot numero, puntos, apagar, supresion_ceros and brillo, and SHALL pulse frame_tick high for that single clk. All digits of the frame SHALL use the snapshot; mid-frame input changes SHALL have no effect until the next frame.
REQ-014 Decode SHALL follow the hex table, pGFEDCBA with p=0:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
- 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- bit 7 SHALL equal the snapshot puntos[i].
REQ-015 Digit i SHALL be blanked (digit line inactive, all segments off) when either condition holds:
- apagar[i]=1; or
- supresion_ceros=1, nibble i=0, and all more-significant nibbles are 0.
Digit 0 SHALL never be zero-suppressed, but SHALL still honour apagar[0].
REQ-016 In MUESTRA, the digit line SHALL be active during show-phase tick index k (0-based from phase entry) only if k*16 < (brillo+1)*T_MUESTRA, evaluated at full width without overflow.
- Outside that window, the digit line SHALL be inactive and all segments off.
- brillo=15 SHALL give a full-phase lit window.
REQ-017 In BLANKING, all digit lines SHALL be inactive and all segments SHALL be off.
REQ-018 Polarity SHALL be applied at the output registers only: "off/inactive" SHALL mean logic 1 when the corresponding *_ACT_BAJO=1, and logic 0 otherwise.
REQ-019 Exactly one digit line SHALL be active at any time, or none.

Reset
REQ-020 While reset_n=0, regardless of clk, the block SHALL hold:
- digitos all inactive, segmentos all off, frame_tick=0
- prescaler=0, state=BLANKING, index=0, counter=0, snapshot=0
REQ-021 After release, the first tick SHALL enter MUESTRA(N-1) with a snapshot and frame_tick. Reset asserted mid-phase SHALL force the REQ-020 values immediately.

Verification (N_DIGITOS=4, CLK_DIV=4, T_MUESTRA=8, T_BLANKING=2, defaults otherwise)
REQ-022 Reset release, numero=16'h12AF, brillo=15 -> digitos=1111, segmentos=00 for 4 clk. Then digitos=0111 with segmentos=06 for 32 clk, followed by 1111/00 for 8 clk. Then 1011/5B, 1101/77, 1110/71 in turn, with a frame_tick every 160 clk.
REQ-023 numero=16'h0070, supresion_ceros=1 -> digits 3 and 2 blank (digitos=1111 during their show phases), digit 1 shows 07, digit 0 shows 3F. With numero=0, only digit 0 is lit, showing 3F.
REQ-024 puntos=4'b0100, apagar=4'b0001, numero=16'h8888 -> digit 2 shows FF, digits 3 and 1 show 7F, digit 0 stays dark.
REQ-025 brillo=0 -> each digit is lit for 1 tick (4 clk) then dark for 7 ticks. brillo=7 -> lit for 4 ticks, dark for 4 ticks.
REQ-026 numero changed from 16'h1111 to 16'h2222 during MUESTRA(2) -> digits 2..0 of the current frame show 06, and the next frame shows 5B on all digits.
REQ-027 reset_n pulsed low mid-MUESTRA -> outputs go inactive within the same clk, without waiting for an edge, and the REQ-022 sequence restarts after release.
